move_drop_ctrl: RTL and testbench
=================================

// Module: move_drop_ctrl
// PURPOSE
//   Sits directly upstream of the turn toggle flip-flop in the Connect-4 datapath.
//   Accepts a column-drop request and finds the landing row from per-column height counters.
//   Writes the current player's colour into the board memory.
//   On a legal move, pulses the toggle-enable that flips the turn bit. Illegal moves are rejected without a toggle.
// PARAMETERS
//   COLS   7  number of board columns
//   ROWS   6  number of board rows (row 0 = bottom)
//   COLW   3  width of column index
//   ROWW   3  width of row index / column height
//   ANIM_TICKS 25_000_000  clocks per row step (only used with DROP_ANIM_EN)
// PORTS
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous, active-low reset
//   new_game     in   1     synchronous clear of board state, 1-cycle pulse
//   drop_req     in   1     request to drop in drop_col, 1-cycle pulse
//   drop_col     in   COLW  target column, sampled when drop_req accepted
//   turn         in   1     current turn (0 = player1, 1 = player2) from turn flip-flop q
//   cell_we      out  1     board memory write strobe
//   cell_col     out  COLW  write column
//   cell_row     out  ROWW  write row
//   cell_color   out  2     00 empty, 01 player1, 10 player2
//   turn_toggle  out  1     1-cycle enable to turn flip-flop
//   drop_ok      out  1     1-cycle pulse, move committed
//   drop_reject  out  1     1-cycle pulse, illegal column or column full
//   busy         out  1     high whenever state != IDLE
//   board_full   out  1     level, all COLS*ROWS cells occupied
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, all heights=0, move_cnt=0; every output 0.
//   - FSM: IDLE -> CHECK -> WRITE -> DONE -> IDLE.  Illegal path: IDLE -> CHECK -> REJECT -> IDLE.
//   - IDLE: if drop_req=1, latch drop_col into col_q and colour {turn,~turn} into clr_q; go to CHECK.
//     drop_req is ignored when state != IDLE (no queueing).
//   - CHECK: if col_q >= COLS or height[col_q] == ROWS, go to REJECT; otherwise go to WRITE.
//   - WRITE: cell_we=1, cell_col=col_q, cell_row=height[col_q], cell_color=clr_q.
//     height[col_q] and move_cnt increment at the end of this cycle.
//   - DONE: turn_toggle=1 and drop_ok=1 for exactly one cycle.
//   - REJECT: drop_reject=1 for one cycle; no write, no toggle.
//   - Latency: drop_req at edge N gives cell_we during cycle N+2 and turn_toggle during N+3.
//   - Colour is latched at accept time, so a turn change mid-move cannot alter the written colour.
//   - board_full = (move_cnt == COLS*ROWS). While board_full, every request takes the REJECT path.
//   - new_game has priority over drop_req and over every state: next edge -> IDLE with heights and move_cnt cleared.
//     In-flight outputs drop to 0 and no turn_toggle is issued. The turn bit is cleared separately by the top level.
//   - Height counters saturate at ROWS; they never wrap.
// CONFIGURATION
//   DROP_ANIM_EN defined: WRITE becomes a falling animation.
//     Start at row ROWS-1; every ANIM_TICKS cycles, write clr_q at the current row and 00 at the row above it.
//     The row above is not written on the first step.
//     Step down until reaching the target row, then go to DONE. busy stays high throughout.
//   DROP_ANIM_EN undefined: single-cycle WRITE as above; the ANIM_TICKS counter is not instantiated.
// STRUCTURE
//   connect4_pkg: COLS/ROWS defaults, colour constants (EMPTY=2'b00, P1=2'b01, P2=2'b10), FSM state encodings.
//   Sub-module col_height_file: COLS x ROWW counters.
//     Ports: clk, reset, clr, inc, inc_col, rd_col, rd_height, rd_full.
// TESTING
//   1. Reset then drop_req col=3, turn=0 -> cell_we@N+2 (3,0,01), turn_toggle@N+3, height[3]=1.
//   2. Six drops in col 0 alternating turn -> rows 0..5 written; 7th drop -> drop_reject, no cell_we, no toggle.
//   3. drop_col=7 -> drop_reject at N+2; no state change anywhere.
//   4. drop_req pulsed while busy=1 -> ignored; exactly one write and one toggle.
//   5. Fill all 42 cells -> board_full=1; further drop -> reject; new_game -> board_full=0, heights 0.
//   6. Assert reset mid-WRITE (and new_game in CHECK) -> outputs 0 immediately (async) / next edge; no turn_toggle.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants: board geometry defaults, cell colour codes and
// the move/drop controller state encoding.
package connect4_pkg;

    localparam int DEF_COLS = 7;
    localparam int DEF_ROWS = 6;
    localparam int DEF_COLW = 3;
    localparam int DEF_ROWW = 3;

    localparam logic [1:0] CLR_EMPTY = 2'b00;
    localparam logic [1:0] CLR_P1    = 2'b01;
    localparam logic [1:0] CLR_P2    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_REJECT = 3'd4
    } drop_state_e;

endpackage

// File: rtl/col_height_file.sv
// Per-column fill counters: one saturating ROWW-bit height per column with a
// synchronous clear and a combinational read port.
module col_height_file
    import connect4_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int COLW = DEF_COLW,
    parameter int ROWW = DEF_ROWW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic [COLW-1:0] inc_col,
    input  logic [COLW-1:0] rd_col,
    output logic [ROWW-1:0] rd_height,
    output logic            rd_full
);

    logic [ROWW-1:0] height_r [COLS];
    logic [ROWW-1:0] rd_height_s;

    // Height update: clear wins over increment, increment saturates at ROWS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < COLS; i++) begin
                height_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < COLS; i++) begin
                height_r[i] <= '0;
            end
        end else if (inc && (int'(inc_col) < COLS) &&
                     (height_r[inc_col] != ROWW'(ROWS))) begin
            height_r[inc_col] <= height_r[inc_col] + ROWW'(1);
        end
    end

    // Read port; out-of-range columns read as empty.
    always_comb begin
        rd_height_s = '0;
        if (int'(rd_col) < COLS) begin
            rd_height_s = height_r[rd_col];
        end else begin
            rd_height_s = '0;
        end
    end

    assign rd_height = rd_height_s;
    assign rd_full   = (rd_height_s == ROWW'(ROWS));

endmodule

// File: rtl/move_drop_ctrl.sv
// Connect-4 move/drop controller: validates a column drop, writes the player's
// colour into the board and pulses the turn toggle. Optional DROP_ANIM_EN adds a falling animation.
module move_drop_ctrl
    import connect4_pkg::*;
#(
`ifdef DROP_ANIM_EN
    parameter int ANIM_TICKS = 25_000_000,
`endif
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int COLW = DEF_COLW,
    parameter int ROWW = DEF_ROWW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    input  logic            drop_req,
    input  logic [COLW-1:0] drop_col,
    input  logic            turn,
    output logic            cell_we,
    output logic [COLW-1:0] cell_col,
    output logic [ROWW-1:0] cell_row,
    output logic [1:0]      cell_color,
    output logic            turn_toggle,
    output logic            drop_ok,
    output logic            drop_reject,
    output logic            busy,
    output logic            board_full
);

    localparam int CELLS = COLS * ROWS;
    localparam int MCW   = $clog2(CELLS + 1);

    drop_state_e     state_r;
    logic [COLW-1:0] col_q_r;
    logic [1:0]      clr_q_r;
    logic [MCW-1:0]  move_cnt_r;
    logic            board_full_r;
    logic            cell_we_r;
    logic [COLW-1:0] cell_col_r;
    logic [ROWW-1:0] cell_row_r;
    logic [1:0]      cell_color_r;
    logic            turn_toggle_r;
    logic            drop_ok_r;
    logic            drop_reject_r;
    logic            busy_r;
    logic [ROWW-1:0] rd_height_s;
    logic            rd_full_s;
    logic            write_done_s;

`ifdef DROP_ANIM_EN
    localparam int TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    logic [TW-1:0]   tick_r;
    logic [ROWW-1:0] anim_row_r;
    logic [ROWW-1:0] tgt_row_r;
    logic [ROWW-1:0] erase_row_r;
    logic            first_r;
    logic            erase_r;
    logic            last_r;

    // The animation ends once the landing row is painted and the trail erased.
    assign write_done_s = (state_r == ST_WRITE) && last_r && !erase_r;
`else
    assign write_done_s = (state_r == ST_WRITE);
`endif

    col_height_file #(
        .COLS (COLS),
        .ROWS (ROWS),
        .COLW (COLW),
        .ROWW (ROWW)
    ) u_heights (
        .clk       (clk),
        .reset     (reset),
        .clr       (new_game),
        .inc       (write_done_s),
        .inc_col   (col_q_r),
        .rd_col    (col_q_r),
        .rd_height (rd_height_s),
        .rd_full   (rd_full_s)
    );

    // Drop sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            col_q_r       <= '0;
            clr_q_r       <= CLR_EMPTY;
            move_cnt_r    <= '0;
            board_full_r  <= 1'b0;
            cell_we_r     <= 1'b0;
            cell_col_r    <= '0;
            cell_row_r    <= '0;
            cell_color_r  <= CLR_EMPTY;
            turn_toggle_r <= 1'b0;
            drop_ok_r     <= 1'b0;
            drop_reject_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef DROP_ANIM_EN
            tick_r        <= '0;
            anim_row_r    <= '0;
            tgt_row_r     <= '0;
            erase_row_r   <= '0;
            first_r       <= 1'b0;
            erase_r       <= 1'b0;
            last_r        <= 1'b0;
`endif
        end else if (new_game) begin
            state_r       <= ST_IDLE;
            move_cnt_r    <= '0;
            board_full_r  <= 1'b0;
            cell_we_r     <= 1'b0;
            cell_col_r    <= '0;
            cell_row_r    <= '0;
            cell_color_r  <= CLR_EMPTY;
            turn_toggle_r <= 1'b0;
            drop_ok_r     <= 1'b0;
            drop_reject_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef DROP_ANIM_EN
            erase_r       <= 1'b0;
            last_r        <= 1'b0;
`endif
        end else begin
            cell_we_r     <= 1'b0;
            cell_col_r    <= '0;
            cell_row_r    <= '0;
            cell_color_r  <= CLR_EMPTY;
            turn_toggle_r <= 1'b0;
            drop_ok_r     <= 1'b0;
            drop_reject_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Colour is captured here so a mid-move turn change cannot leak in.
                    if (drop_req) begin
                        col_q_r <= drop_col;
                        clr_q_r <= {turn, ~turn};
                        state_r <= ST_CHECK;
                        busy_r  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if ((int'(col_q_r) >= COLS) || rd_full_s || board_full_r) begin
                        state_r       <= ST_REJECT;
                        drop_reject_r <= 1'b1;
                    end else begin
                        state_r <= ST_WRITE;
`ifdef DROP_ANIM_EN
                        tick_r     <= '0;
                        anim_row_r <= ROWW'(ROWS - 1);
                        tgt_row_r  <= rd_height_s;
                        first_r    <= 1'b1;
                        erase_r    <= 1'b0;
                        last_r     <= 1'b0;
`else
                        cell_we_r    <= 1'b1;
                        cell_col_r   <= col_q_r;
                        cell_row_r   <= rd_height_s;
                        cell_color_r <= clr_q_r;
`endif
                    end
                end
                ST_WRITE: begin
                    if (write_done_s) begin
                        state_r       <= ST_DONE;
                        turn_toggle_r <= 1'b1;
                        drop_ok_r     <= 1'b1;
                        move_cnt_r    <= move_cnt_r + MCW'(1);
                        board_full_r  <= (move_cnt_r == MCW'(CELLS - 1));
`ifdef DROP_ANIM_EN
                        last_r        <= 1'b0;
                    end else if (erase_r) begin
                        cell_we_r    <= 1'b1;
                        cell_col_r   <= col_q_r;
                        cell_row_r   <= erase_row_r;
                        cell_color_r <= CLR_EMPTY;
                        erase_r      <= 1'b0;
                    end else if (tick_r == TW'(ANIM_TICKS - 1)) begin
                        tick_r       <= '0;
                        cell_we_r    <= 1'b1;
                        cell_col_r   <= col_q_r;
                        cell_row_r   <= anim_row_r;
                        cell_color_r <= clr_q_r;
                        erase_r      <= ~first_r;
                        erase_row_r  <= anim_row_r + ROWW'(1);
                        first_r      <= 1'b0;
                        if (anim_row_r == tgt_row_r) begin
                            last_r <= 1'b1;
                        end else begin
                            anim_row_r <= anim_row_r - ROWW'(1);
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
`endif
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_REJECT: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cell_we     = cell_we_r;
    assign cell_col    = cell_col_r;
    assign cell_row    = cell_row_r;
    assign cell_color  = cell_color_r;
    assign turn_toggle = turn_toggle_r;
    assign drop_ok     = drop_ok_r;
    assign drop_reject = drop_reject_r;
    assign busy        = busy_r;
    assign board_full  = board_full_r;

endmodule

// File: tb/tb_move_drop_ctrl.sv
// Self-checking bench for move_drop_ctrl: vector table, scoreboard of expected
// writes/rejects, and hand sequences for busy, board-full, reset and new_game cases.
module tb_move_drop_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       drop_req = 1'b0;
    logic [2:0] drop_col = 3'd0;
    logic       turn = 1'b0;
    logic       cell_we;
    logic [2:0] cell_col;
    logic [2:0] cell_row;
    logic [1:0] cell_color;
    logic       turn_toggle;
    logic       drop_ok;
    logic       drop_reject;
    logic       busy;
    logic       board_full;

    int   errors = 0;
    int   checks = 0;
    int   toggle_cnt = 0;
    int   tcnt = 0;
    logic we_prev = 1'b0;
    logic fill_turn = 1'b0;
    int   hts [7];

    typedef struct packed {
        logic       legal;
        logic [2:0] col;
        logic [2:0] row;
        logic [1:0] color;
    } exp_t;
    exp_t sb_q [$];

    typedef struct {
        logic [2:0] col;
        logic       turn;
        logic       legal;
        logic [2:0] row;
    } vec_t;
    vec_t vecs [11];

    move_drop_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .drop_req    (drop_req),
        .drop_col    (drop_col),
        .turn        (turn),
        .cell_we     (cell_we),
        .cell_col    (cell_col),
        .cell_row    (cell_row),
        .cell_color  (cell_color),
        .turn_toggle (turn_toggle),
        .drop_ok     (drop_ok),
        .drop_reject (drop_reject),
        .busy        (busy),
        .board_full  (board_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write or reject must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cell_we || drop_reject) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 32'({cell_we, drop_reject}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_we", 32'(cell_we), 32'(e.legal));
                chk("sb_reject", 32'(drop_reject), 32'(!e.legal));
                if (e.legal) begin
                    chk("sb_col", 32'(cell_col), 32'(e.col));
                    chk("sb_row", 32'(cell_row), 32'(e.row));
                    chk("sb_color", 32'(cell_color), 32'(e.color));
                end
            end
        end
        if (turn_toggle) begin
            toggle_cnt++;
            chk("toggle_after_write", 32'(we_prev), 32'd1);
        end
        we_prev = cell_we;
    end

    task automatic do_drop(input logic [2:0] col, input logic t, input logic legal,
                           input logic [2:0] row);
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = col;
        turn     = t;
        sb_q.push_back({legal, col, row, (t ? 2'b10 : 2'b01)});
        @(negedge clk);
        drop_req = 1'b0;
        #1;
        chk("n1_busy", 32'(busy), 32'd1);
        chk("n1_no_we", 32'(cell_we), 32'd0);
        @(negedge clk);
        #1;
        chk("n2_we", 32'(cell_we), 32'(legal));
        chk("n2_reject", 32'(drop_reject), 32'(!legal));
        @(negedge clk);
        #1;
        chk("n3_toggle", 32'(turn_toggle), 32'(legal));
        chk("n3_ok", 32'(drop_ok), 32'(legal));
        chk("n3_busy", 32'(busy), 32'(legal));
        @(negedge clk);
        #1;
        chk("n4_idle", 32'(busy), 32'd0);
        chk("n4_no_toggle", 32'(turn_toggle), 32'd0);
        if (legal) hts[col]++;
    endtask

    initial begin
        vecs[0]  = '{3'd3, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{3'd0, 1'b0, 1'b1, 3'd0};
        vecs[2]  = '{3'd0, 1'b1, 1'b1, 3'd1};
        vecs[3]  = '{3'd0, 1'b0, 1'b1, 3'd2};
        vecs[4]  = '{3'd0, 1'b1, 1'b1, 3'd3};
        vecs[5]  = '{3'd0, 1'b0, 1'b1, 3'd4};
        vecs[6]  = '{3'd0, 1'b1, 1'b1, 3'd5};
        vecs[7]  = '{3'd0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{3'd7, 1'b1, 1'b0, 3'd0};
        vecs[9]  = '{3'd3, 1'b1, 1'b1, 3'd1};
        vecs[10] = '{3'd6, 1'b0, 1'b1, 3'd0};
        for (int i = 0; i < 7; i++) hts[i] = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_we", 32'(cell_we), 32'd0);
        chk("rst_col", 32'(cell_col), 32'd0);
        chk("rst_row", 32'(cell_row), 32'd0);
        chk("rst_color", 32'(cell_color), 32'd0);
        chk("rst_toggle", 32'(turn_toggle), 32'd0);
        chk("rst_ok", 32'(drop_ok), 32'd0);
        chk("rst_reject", 32'(drop_reject), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(board_full), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_drop(vecs[i].col, vecs[i].turn, vecs[i].legal, vecs[i].row);
        end

        // Requests while busy are dropped; turn changes mid-move do not alter the colour.
        @(negedge clk);
        tcnt = toggle_cnt;
        drop_req = 1'b1;
        drop_col = 3'd1;
        turn     = 1'b1;
        sb_q.push_back({1'b1, 3'd1, 3'(hts[1]), 2'b10});
        @(negedge clk);
        drop_col = 3'd6;
        turn     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drop_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("busy_ignore_toggles", 32'(toggle_cnt - tcnt), 32'd1);
        chk("busy_ignore_sb_empty", 32'(sb_q.size()), 32'd0);
        hts[1]++;
        do_drop(3'd6, 1'b1, 1'b1, 3'(hts[6]));

        // Fill every remaining cell.
        for (int c = 0; c < 7; c++) begin
            while (hts[c] < 6) begin
                do_drop(3'(c), fill_turn, 1'b1, 3'(hts[c]));
                fill_turn = ~fill_turn;
            end
        end
        @(negedge clk);
        #1;
        chk("board_full_set", 32'(board_full), 32'd1);
        do_drop(3'd2, 1'b0, 1'b0, 3'd0);
        chk("board_full_hold", 32'(board_full), 32'd1);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        #1;
        chk("new_game_full_clr", 32'(board_full), 32'd0);
        chk("new_game_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 7; i++) hts[i] = 0;
        do_drop(3'd4, 1'b0, 1'b1, 3'd0);
        do_drop(3'd4, 1'b1, 1'b1, 3'd1);

        // Asynchronous reset while the write strobe is up.
        @(negedge clk);
        tcnt = toggle_cnt;
        drop_req = 1'b1;
        drop_col = 3'd5;
        turn     = 1'b0;
        sb_q.push_back({1'b1, 3'd5, 3'd0, 2'b01});
        @(negedge clk);
        drop_req = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_write_we", 32'(cell_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_we", 32'(cell_we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_color", 32'(cell_color), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("async_rst_no_toggle", 32'(toggle_cnt - tcnt), 32'd0);
        for (int i = 0; i < 7; i++) hts[i] = 0;

        // new_game while in CHECK aborts the move.
        tcnt = toggle_cnt;
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = 3'd2;
        turn     = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        new_game = 1'b1;
        #1;
        chk("ng_in_check_busy", 32'(busy), 32'd1);
        @(negedge clk);
        new_game = 1'b0;
        #1;
        chk("ng_abort_busy", 32'(busy), 32'd0);
        chk("ng_abort_we", 32'(cell_we), 32'd0);
        chk("ng_abort_reject", 32'(drop_reject), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ng_abort_no_toggle", 32'(toggle_cnt - tcnt), 32'd0);
        do_drop(3'd2, 1'b1, 1'b1, 3'd0);
        do_drop(3'd5, 1'b0, 1'b1, 3'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
